// File: rtl/gray_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gray_pkg : block sizes, arbiter state type, rgb->gray arithmetic |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package gray_pkg;

    localparam int BLOCK_BYTES = 243;
    localparam int PIXELS      = BLOCK_BYTES / 3;

    localparam logic [7:0] BYTE_LAST = 8'(BLOCK_BYTES - 1);
    localparam logic [6:0] PIX_LAST  = 7'(PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // Fixed-point BT.601 weights with rounding; result fits in 8 bits.
    function automatic logic [7:0] rgb_to_gray(input logic [7:0] r,
                                               input logic [7:0] g,
                                               input logic [7:0] b);
        logic [22:0] acc;
        acc = 23'd2048
            + 23'd1225 * {15'd0, r}
            + 23'd2404 * {15'd0, g}
            + 23'd467  * {15'd0, b};
        return 8'(acc >> 12);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gray_arbiter_if : requester-side and result-side bus bundle      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface gray_arbiter_if;

    logic        i_req0;
    logic        i_req1;
    logic        i_vld0;
    logic        i_vld1;
    logic [7:0]  i_data0;
    logic [7:0]  i_data1;
    logic        o_gnt0;
    logic        o_gnt1;
    logic [7:0]  o_gray;
    logic        o_gvld0;
    logic        o_gvld1;
    logic        o_last;
    logic        o_busy;
    logic [15:0] o_cnt0;
    logic [15:0] o_cnt1;

    modport master (
        output i_req0, i_req1, i_vld0, i_vld1, i_data0, i_data1,
        input  o_gnt0, o_gnt1, o_gray, o_gvld0, o_gvld1, o_last, o_busy,
               o_cnt0, o_cnt1
    );

    modport slave (
        input  i_req0, i_req1, i_vld0, i_vld1, i_data0, i_data1,
        output o_gnt0, o_gnt1, o_gray, o_gvld0, o_gvld1, o_last, o_busy,
               o_cnt0, o_cnt1
    );

endinterface
`default_nettype wire

// File: rtl/gray_arbiter_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gray_arbiter_engine : buffers one 81-pixel block, then streams   |
// | its gray values out one per cycle.  Rev 1.0                      |
// +------------------------------------------------------------------+
module gray_arbiter_engine
    import gray_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [7:0] i_byte,
    output logic       o_valid,
    output logic [7:0] o_gray
);

    logic       en_q;
    logic [7:0] byte_q;
    logic [1:0] phase_q;
    logic [7:0] red_q;
    logic [7:0] grn_q;
    logic [6:0] wr_idx_q;
    logic [6:0] rd_idx_q;
    logic       run_q;
    logic       valid_q;
    logic [7:0] gray_q;
    logic [7:0] mem_q [PIXELS];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            en_q     <= 1'b0;
            byte_q   <= 8'd0;
            phase_q  <= 2'd0;
            red_q    <= 8'd0;
            grn_q    <= 8'd0;
            wr_idx_q <= 7'd0;
            rd_idx_q <= 7'd0;
            run_q    <= 1'b0;
            valid_q  <= 1'b0;
            gray_q   <= 8'd0;
        end else begin
            en_q    <= i_en;
            byte_q  <= i_byte;
            valid_q <= run_q;
            if (run_q) begin
                gray_q <= mem_q[rd_idx_q];
                if (rd_idx_q == PIX_LAST) begin
                    run_q <= 1'b0;
                end else begin
                    rd_idx_q <= rd_idx_q + 7'd1;
                end
            end
            // The blue byte completes a pixel; the 81st pixel starts playback.
            if (en_q) begin
                case (phase_q)
                    2'd0: begin
                        red_q   <= byte_q;
                        phase_q <= 2'd1;
                    end
                    2'd1: begin
                        grn_q   <= byte_q;
                        phase_q <= 2'd2;
                    end
                    default: begin
                        phase_q <= 2'd0;
                        if (wr_idx_q == PIX_LAST) begin
                            wr_idx_q <= 7'd0;
                            rd_idx_q <= 7'd0;
                            run_q    <= 1'b1;
                        end else begin
                            wr_idx_q <= wr_idx_q + 7'd1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (en_q && (phase_q == 2'd2)) begin
            mem_q[wr_idx_q] <= rgb_to_gray(red_q, grn_q, byte_q);
        end
    end

    assign o_valid = valid_q;
    assign o_gray  = gray_q;

endmodule
`default_nettype wire

// File: rtl/gray_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gray_arbiter : round-robin sharing of one rgb2gray engine by two |
// | block requesters.  Rev 1.0                                       |
// +------------------------------------------------------------------+
module gray_arbiter
    import gray_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    gray_arbiter_if.slave bus
);

    arb_state_t  state_q, state_d;
    logic        sel_q, sel_d;
    logic        last_srv_q, last_srv_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [6:0]  res_cnt_q, res_cnt_d;
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    logic        w_vld;
    logic        w_en;
    logic [7:0]  w_byte;
    logic        w_res;
    logic        w_last;
    logic        w_eng_vld;
    logic [7:0]  w_eng_gray;

    gray_arbiter_engine u_engine (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (w_en),
        .i_byte  (w_byte),
        .o_valid (w_eng_vld),
        .o_gray  (w_eng_gray)
    );

    always_comb begin
        w_vld      = sel_q ? bus.i_vld1  : bus.i_vld0;
        w_byte     = sel_q ? bus.i_data1 : bus.i_data0;
        w_en       = (state_q == LOAD) && w_vld;
        w_res      = (state_q == DRAIN) && w_eng_vld;
        w_last     = w_res && (res_cnt_q == PIX_LAST);

        state_d    = state_q;
        sel_d      = sel_q;
        last_srv_d = last_srv_q;
        byte_cnt_d = byte_cnt_q;
        res_cnt_d  = res_cnt_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;

        case (state_q)
            IDLE: begin
                // On a tie the requester not served last wins.
                if (bus.i_req0 || bus.i_req1) begin
                    sel_d   = (bus.i_req0 && bus.i_req1) ? ~last_srv_q : bus.i_req1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (w_en) begin
                    if (byte_cnt_q == BYTE_LAST) begin
                        byte_cnt_d = 8'd0;
                        state_d    = DRAIN;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end
            end
            DRAIN: begin
                if (w_res) begin
                    if (w_last) begin
                        res_cnt_d  = 7'd0;
                        last_srv_d = sel_q;
                        state_d    = IDLE;
                        if (sel_q) cnt1_d = cnt1_q + 16'd1;
                        else       cnt0_d = cnt0_q + 16'd1;
                    end else begin
                        res_cnt_d = res_cnt_q + 7'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            last_srv_q <= 1'b1;
            byte_cnt_q <= 8'd0;
            res_cnt_q  <= 7'd0;
            cnt0_q     <= 16'd0;
            cnt1_q     <= 16'd0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_srv_q <= last_srv_d;
            byte_cnt_q <= byte_cnt_d;
            res_cnt_q  <= res_cnt_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
        end
    end

    assign bus.o_busy  = (state_q != IDLE);
    assign bus.o_gnt0  = (state_q != IDLE) && !sel_q;
    assign bus.o_gnt1  = (state_q != IDLE) &&  sel_q;
    assign bus.o_gray  = w_res ? w_eng_gray : 8'd0;
    assign bus.o_gvld0 = w_res && !sel_q;
    assign bus.o_gvld1 = w_res &&  sel_q;
    assign bus.o_last  = w_last;
    assign bus.o_cnt0  = cnt0_q;
    assign bus.o_cnt1  = cnt1_q;

endmodule
`default_nettype wire

// File: doc/gray_arbiter.md
# gray_arbiter

Shares one rgb2gray conversion engine between two pixel-block requesters. Grants the engine to one requester for a whole 243-byte (81-pixel RGB) block, forwards that requester's bytes into the engine, and routes the 81 gray results back to it with a per-requester valid. Uses round-robin priority. Sits between the two capture front-ends and the single conversion engine.

## Interface
- BLOCK_BYTES, 243: bytes per block. Must equal the engine's input length.
- PIXELS, BLOCK_BYTES/3 (81): results per block.
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset. Also drives the engine reset.
- i_req0, i_req1  in  1  requester k has a full block ready. Level signal, held until o_gntk rises.
- i_vld0, i_vld1  in  1  byte valid from requester k. Honoured only while k is granted and in LOAD.
- i_data0, i_data1  in  8  byte stream for requester k, in R,G,B order.
- o_gnt0, o_gnt1  out  1  one-hot grant. Held from grant until the block's last result.
- o_gray  out  8  shared result bus.
- o_gvld0, o_gvld1  out  1  o_gray belongs to requester k this cycle.
- o_last  out  1  marks the 81st result of a block.
- o_busy  out  1  state is not IDLE.
- o_cnt0, o_cnt1  out  16  completed blocks per requester. Wraps modulo 2^16.

## Operation
- FSM states: IDLE, LOAD, DRAIN.
- IDLE
  - If any request is pending, pick the winner and go to LOAD; o_gntk asserts on the next edge.
  - If both request, the requester not served last wins. After reset, "last served" = 1, so requester 0 wins the first tie.
- LOAD
  - Engine enable = i_vldk of the granted k; engine byte = i_datak. Both are combinational, and the engine registers them.
  - byte_cnt increments per accepted byte.
  - On the accept with byte_cnt == BLOCK_BYTES-1: clear byte_cnt and go to DRAIN.
  - Bytes from the non-granted requester are ignored. Gaps in i_vld are allowed and unbounded.
- DRAIN
  - Engine enable is forced 0.
  - Each engine valid: o_gray = engine result, o_gvldk = 1, res_cnt increments.
  - On the result with res_cnt == PIXELS-1: assert o_last, increment o_cntk, update last-served to k, drop the grant, go to IDLE.
- Requests arriving during LOAD/DRAIN wait. Deasserting i_reqk after grant has no effect; the block must complete.
- Reset at any time:
  - FSM → IDLE, counters 0, last-served = 1.
  - The engine is reset in the same cycle, so a partial block is discarded and no stale results are emitted.
- Engine arithmetic (for checking): gray = (2048 + 1225·R + 2404·G + 467·B) >> 12, using a 23-bit intermediate and truncating to 8 bits.

## Timing
- Reset values: o_gnt0/1 = 0, o_gray = 0, o_gvld0/1 = 0, o_last = 0, o_busy = 0, o_cnt0/1 = 0.
- Request seen in IDLE at edge E → o_gntk high after E. The first byte can be accepted in the cycle after E.
- Last byte accepted at edge T → engine processes over T+1..T+81 → results valid on cycles T+2..T+82, one per cycle with no gaps.
- o_last is asserted at T+82. The FSM is in IDLE after T+83, and a new grant is possible on the edge after that.
- Minimum block turnaround: 243 load cycles + 83 cycles.
- The grant never changes while o_busy = 1.

## Structure
- Shared package gray_pkg:
  - BLOCK_BYTES and PIXELS constants.
  - The arb_state_t enum {IDLE, LOAD, DRAIN}, reused by later multi-port controllers.
- One natural sub-module: the rgb2gray engine instance (u_engine). The instance is kept inside so that no requester can reach the engine directly.
- Round-robin pick and counters stay inline.

## Test plan
- Req0 only, 243 bytes all 100 back-to-back → 81 results of 100 on o_gvld0 at T+2..T+82, o_last at T+82, o_cnt0 = 1.
- One pixel each of (255,0,0), (0,255,0), (0,0,255), (255,255,255) → results 76, 150, 29, 255 in order.
- i_req0 and i_req1 asserted in the same cycle after reset → 0 served first, then 1. With both held, grants alternate 0,1,0,1.
- Req1 granted, i_vld1 toggling 1/0, with i_vld0 = 1 and junk on i_data0 throughout → only req1 bytes loaded; results appear on o_gvld1 only.
- i_rst pulsed at byte 100 of LOAD, then a fresh 243-byte block on req0 → exactly 81 correct results with no leftover outputs; o_cnt0 = 1.
- i_rst pulsed at result 40 of DRAIN → no o_gvld pulses after reset; o_busy = 0; next grant goes to requester 0.
